// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: two ports sharing one address map, with output
// registers and debounced switch inputs with edge flags and interrupt.
module mmio_ctrl #(
    parameter int WIDTH    = 16,
    parameter int ADDRBITS = 10,
    parameter int NOUT     = 2,
    parameter int NSW      = 10,
    parameter int DEBOUNCE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDRBITS-1:0]   addr_a,
    input  logic [ADDRBITS-1:0]   addr_b,
    input  logic [WIDTH-1:0]      wd_a,
    input  logic [WIDTH-1:0]      wd_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [WIDTH-1:0]      memq_a,
    input  logic [WIDTH-1:0]      memq_b,
    input  logic [NSW-1:0]        switches,
    output logic [WIDTH-1:0]      rdata_a,
    output logic [WIDTH-1:0]      rdata_b,
    output logic [NOUT*WIDTH-1:0] outregs,
    output logic                  irq
);

    localparam int               CNT_W       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE - 1);
    localparam logic [3:0]       OFF_SW_DATA = 4'd8;
    localparam logic [3:0]       OFF_SW_EDGE = 4'd9;
    localparam logic [3:0]       OFF_IRQ_EN  = 4'd10;

    logic             io_a, io_b, wr_a, wr_b;
    logic [3:0]       off_a, off_b;
    logic [WIDTH-1:0] out_q [NOUT];
    logic [WIDTH-1:0] out_d [NOUT];
    logic [NSW-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NSW-1:0]   deb_q, deb_d, sw_edge_q, sw_edge_d, irq_en_q, irq_en_d;
    logic [NSW-1:0]   clr_mask;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;
    logic             sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [3:0]       off_a_q, off_a_d, off_b_q, off_b_d;
    logic [WIDTH-1:0] view [16];
    logic             unused_addr;

    // Upper address bits inside I/O space are don't-care, so the map aliases.
    assign io_a        = (addr_a[ADDRBITS-1 -: 2] == 2'b11);
    assign io_b        = (addr_b[ADDRBITS-1 -: 2] == 2'b11);
    assign off_a       = addr_a[3:0];
    assign off_b       = addr_b[3:0];
    assign wr_a        = we_a & io_a;
    assign wr_b        = we_b & io_b;
    assign unused_addr = ^{addr_a, addr_b};

    always_comb begin
        sync1_d = switches;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // One shared counter: any mismatch run of DEBOUNCE edges is accepted.
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NOUT; k++) begin
            out_d[k] = out_q[k];
            if (wr_b && off_b == 4'(k)) out_d[k] = wd_b;
            if (wr_a && off_a == 4'(k)) out_d[k] = wd_a;
        end
        irq_en_d = irq_en_q;
        if (wr_b && off_b == OFF_IRQ_EN) irq_en_d = wd_b[NSW-1:0];
        if (wr_a && off_a == OFF_IRQ_EN) irq_en_d = wd_a[NSW-1:0];
        clr_mask = '0;
        if (wr_a && off_a == OFF_SW_EDGE) begin
            clr_mask = wd_a[NSW-1:0];
        end else if (wr_b && off_b == OFF_SW_EDGE) begin
            clr_mask = wd_b[NSW-1:0];
        end
        // A new rising edge beats a simultaneous write-1-to-clear.
        sw_edge_d = (sw_edge_q & ~clr_mask) | (deb_d & ~deb_q);
        irq_d     = |(sw_edge_d & irq_en_d);
        sel_a_d   = io_a;
        sel_b_d   = io_b;
        off_a_d   = off_a;
        off_b_d   = off_b;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NOUT; k++) out_q[k] <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            cnt_q     <= '0;
            sw_edge_q <= '0;
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
            sel_a_q   <= 1'b0;
            sel_b_q   <= 1'b0;
            off_a_q   <= '0;
            off_b_q   <= '0;
        end else begin
            for (int k = 0; k < NOUT; k++) out_q[k] <= out_d[k];
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            sw_edge_q <= sw_edge_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            off_a_q   <= off_a_d;
            off_b_q   <= off_b_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) view[i] = '0;
        for (int k = 0; k < NOUT; k++) view[k] = out_q[k];
        view[OFF_SW_DATA] = WIDTH'(deb_q);
        view[OFF_SW_EDGE] = WIDTH'(sw_edge_q);
        view[OFF_IRQ_EN]  = WIDTH'(irq_en_q);
    end

    // Read data is forced low while reset is held, even though memq is external.
    assign rdata_a = !reset ? '0 : (sel_a_q ? view[off_a_q] : memq_a);
    assign rdata_b = !reset ? '0 : (sel_b_q ? view[off_b_q] : memq_b);
    assign irq     = irq_q;

    for (genvar k = 0; k < NOUT; k++) begin : g_out
        assign outregs[k*WIDTH +: WIDTH] = out_q[k];
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Randomized scoreboard bench for mmio_ctrl against a behavioural register-map model.
module tb_mmio_ctrl;

    localparam int NOUT = 2;
    localparam int DEB  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  addr_a, addr_b;
    logic [15:0] wd_a, wd_b, memq_a, memq_b, rdata_a, rdata_b;
    logic        we_a, we_b, irq;
    logic [9:0]  switches;
    logic [31:0] outregs;

    mmio_ctrl #(.WIDTH(16), .ADDRBITS(10), .NOUT(NOUT), .NSW(10), .DEBOUNCE(DEB)) dut (
        .clk(clk), .reset(reset),
        .addr_a(addr_a), .addr_b(addr_b), .wd_a(wd_a), .wd_b(wd_b),
        .we_a(we_a), .we_b(we_b), .memq_a(memq_a), .memq_b(memq_b),
        .switches(switches), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .outregs(outregs), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [1024];
    always @(posedge clk) begin
        memq_a <= mem[addr_a];
        memq_b <= mem[addr_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register file plus a switch pipeline with a mismatch run length.
    logic [15:0] m_out [NOUT];
    logic [9:0]  m_en, m_edge, m_deb, m_s1, m_s2;
    int          m_run;
    logic        m_irq;

    task automatic model_reset();
        for (int k = 0; k < NOUT; k++) m_out[k] = '0;
        m_en = '0; m_edge = '0; m_deb = '0; m_s1 = '0; m_s2 = '0;
        m_run = 0; m_irq = 1'b0;
    endtask

    function automatic logic [15:0] m_view(input logic [3:0] off);
        if (int'(off) < NOUT) return m_out[off];
        if (off == 4'd8)  return {6'd0, m_deb};
        if (off == 4'd9)  return {6'd0, m_edge};
        if (off == 4'd10) return {6'd0, m_en};
        return 16'h0000;
    endfunction

    typedef struct {
        int          due;
        logic [15:0] ea, eb;
        logic [31:0] eout;
        logic        eirq;
    } sb_t;
    sb_t sbq[$];
    sb_t ent;

    task automatic model_step();
        logic [9:0] newdeb, rise, clr;
        logic       ioa, iob;
        sb_t        e;
        newdeb = m_deb;
        if (m_s2 != m_deb) begin
            m_run++;
            if (m_run == DEB) begin
                newdeb = m_s2;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
        rise  = newdeb & ~m_deb;
        m_deb = newdeb;
        m_s2  = m_s1;
        m_s1  = switches;
        ioa = (addr_a[9:8] == 2'b11);
        iob = (addr_b[9:8] == 2'b11);
        if (we_b && iob) begin
            if (int'(addr_b[3:0]) < NOUT) m_out[addr_b[3:0]] = wd_b;
            if (addr_b[3:0] == 4'd10) m_en = wd_b[9:0];
        end
        if (we_a && ioa) begin
            if (int'(addr_a[3:0]) < NOUT) m_out[addr_a[3:0]] = wd_a;
            if (addr_a[3:0] == 4'd10) m_en = wd_a[9:0];
        end
        clr = '0;
        if (we_a && ioa && addr_a[3:0] == 4'd9) clr = wd_a[9:0];
        else if (we_b && iob && addr_b[3:0] == 4'd9) clr = wd_b[9:0];
        m_edge = (m_edge & ~clr) | rise;
        m_irq  = |(m_edge & m_en);
        e.due  = cyc + 1;
        e.ea   = ioa ? m_view(addr_a[3:0]) : mem[addr_a];
        e.eb   = iob ? m_view(addr_b[3:0]) : mem[addr_b];
        e.eout = {m_out[1], m_out[0]};
        e.eirq = m_irq;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            sbq.delete();
        end else begin
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                ent = sbq.pop_front();
                if (ent.due != cyc) begin
                    chk("sb_stale", 32'(ent.due), 32'(cyc));
                end else begin
                    chk("sb_rdata_a", 32'(rdata_a), 32'(ent.ea));
                    chk("sb_rdata_b", 32'(rdata_b), 32'(ent.eb));
                    chk("sb_outregs", outregs, ent.eout);
                    chk("sb_irq", 32'(irq), 32'(ent.eirq));
                end
            end
        end
    end

    task automatic step(input logic [9:0] aa, input logic wa, input logic [15:0] da,
                        input logic [9:0] ab, input logic wb, input logic [15:0] db);
        addr_a = aa; we_a = wa; wd_a = da;
        addr_b = ab; we_b = wb; wd_b = db;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(10'h000, 1'b0, 16'h0, 10'h000, 1'b0, 16'h0);
    endtask

    task automatic do_reset(input string tag);
        #1 reset = 1'b0;
        #1;
        chk({tag, "_outregs"}, outregs, 32'h0);
        chk({tag, "_irq"}, 32'(irq), 32'h0);
        chk({tag, "_rdata_a"}, 32'(rdata_a), 32'h0);
        chk({tag, "_rdata_b"}, 32'(rdata_b), 32'h0);
        sbq.delete();
        model_reset();
        we_a = 1'b0; we_b = 1'b0; addr_a = '0; addr_b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    function automatic logic [9:0] rand_addr();
        logic [9:0] a;
        if ($urandom_range(9, 0) < 7) begin
            a = {2'b11, 4'($urandom), 4'($urandom_range(15, 0))};
        end else begin
            a = 10'($urandom);
            if (a[9:8] == 2'b11) a[9] = 1'b0;
        end
        return a;
    endfunction

    logic [9:0] sw_r;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[5] = 16'hBEEF;
        reset = 1'b0; switches = '0; we_a = 0; we_b = 0;
        addr_a = '0; addr_b = '0; wd_a = '0; wd_b = '0;
        model_reset();
        #1;
        chk("rst_outregs", outregs, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata_a", 32'(rdata_a), 32'h0);
        chk("rst_rdata_b", 32'(rdata_b), 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // OUT write/read and memory path
        step(10'h300, 1'b1, 16'h1234, 10'h000, 1'b0, 16'h0);
        chk("out0_write", 32'(outregs[15:0]), 32'h1234);
        step(10'h300, 1'b0, 16'h0, 10'h000, 1'b0, 16'h0);
        chk("out0_read", 32'(rdata_a), 32'h1234);
        step(10'h005, 1'b0, 16'h0, 10'h000, 1'b0, 16'h0);
        chk("mem_read", 32'(rdata_a), 32'hBEEF);
        step(10'h005, 1'b1, 16'h0005, 10'h000, 1'b0, 16'h0);
        chk("mem_write_no_reg", outregs, 32'h0000_1234);

        // Collision: port A wins
        step(10'h301, 1'b1, 16'hAAAA, 10'h301, 1'b1, 16'h5555);
        chk("collide_out1", 32'(outregs[31:16]), 32'hAAAA);
        step(10'h000, 1'b0, 16'h0, 10'h301, 1'b0, 16'h0);
        chk("collide_read_b", 32'(rdata_b), 32'hAAAA);

        // Debounce glitch: 3 cycles high is rejected
        switches = 10'h001;
        repeat (3) step(10'h308, 1'b0, 16'h0, 10'h309, 1'b0, 16'h0);
        switches = 10'h000;
        repeat (5) step(10'h308, 1'b0, 16'h0, 10'h309, 1'b0, 16'h0);
        chk("glitch_swdata", 32'(rdata_a), 32'h0);
        chk("glitch_swedge", 32'(rdata_b), 32'h0);

        // Held high: accepted on the 6th edge
        switches = 10'h001;
        repeat (6) step(10'h308, 1'b0, 16'h0, 10'h309, 1'b0, 16'h0);
        chk("held_swdata", 32'(rdata_a), 32'h1);
        chk("held_swedge", 32'(rdata_b), 32'h1);
        repeat (4) idle();

        // Interrupt enable, clear, and clear coincident with a new edge
        step(10'h30A, 1'b1, 16'h0001, 10'h000, 1'b0, 16'h0);
        chk("irq_set", 32'(irq), 32'h1);
        step(10'h309, 1'b1, 16'h0001, 10'h000, 1'b0, 16'h0);
        chk("irq_clear", 32'(irq), 32'h0);
        step(10'h309, 1'b0, 16'h0, 10'h308, 1'b1, 16'hFFFF);
        chk("swedge_cleared", 32'(rdata_a), 32'h0);
        chk("swdata_ro", 32'(rdata_b), 32'h1);
        switches = 10'h000;
        repeat (8) idle();
        step(10'h309, 1'b1, 16'hFFFF, 10'h000, 1'b0, 16'h0);
        switches = 10'h001;
        repeat (5) idle();
        step(10'h309, 1'b1, 16'h0001, 10'h000, 1'b0, 16'h0);
        chk("set_beats_clear_irq", 32'(irq), 32'h1);
        step(10'h309, 1'b0, 16'h0, 10'h000, 1'b0, 16'h0);
        chk("set_beats_clear_flag", 32'(rdata_a), 32'h1);

        // Reset mid-operation
        step(10'h300, 1'b1, 16'hFFFF, 10'h000, 1'b0, 16'h0);
        chk("pre_reset_irq", 32'(irq), 32'h1);
        do_reset("midrst");
        switches = 10'h000;
        step(10'h300, 1'b0, 16'h0, 10'h000, 1'b0, 16'h0);
        chk("post_reset_out0", 32'(rdata_a), 32'h0);

        // Randomized traffic
        sw_r = '0;
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(7, 0) == 0) sw_r = sw_r ^ (10'b1 << $urandom_range(9, 0));
            switches = sw_r;
            step(rand_addr(), 1'($urandom_range(4, 0) < 2), 16'($urandom),
                 rand_addr(), 1'($urandom_range(4, 0) < 2), 16'($urandom));
            if (n == 350) begin
                do_reset("rndrst");
            end
        end

        idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 16, data width.
- ADDRBITS, default 10, address width.
- NOUT, default 2, number of output registers; range 1..8.
- NSW, default 10, switch input width; NSW <= WIDTH.
- DEBOUNCE, default 4, stable cycles required to accept a switch change; DEBOUNCE >= 1.

REQ-002 Ports SHALL be:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low.
- addr_a, addr_b  input  ADDRBITS  port A/B address.
- wd_a, wd_b  input  WIDTH  port A/B write data.
- we_a, we_b  input  1  port A/B write enable.
- memq_a, memq_b  input  WIDTH  port A/B block-RAM read data.
- switches  input  NSW  raw asynchronous switch inputs.
- rdata_a, rdata_b  output  WIDTH  port A/B read data, memory or I/O.
- outregs  output  NOUT*WIDTH  output register bank; register k occupies bits [k*WIDTH +: WIDTH].
- irq  output  1  switch-edge interrupt.

REQ-003 Clock and reset SHALL be named clk and reset; reset is asynchronous and active-low.

Function
REQ-004 A port access SHALL be in I/O space when addr[ADDRBITS-1:ADDRBITS-2] == 2'b11; the register offset is addr[3:0].

REQ-005 Register map SHALL be:
- 0..NOUT-1: OUT[k], read/write.
- 8: SW_DATA, read-only; debounced switches, zero-extended to WIDTH.
- 9: SW_EDGE, sticky rising-edge flags, write-1-to-clear.
- 10: IRQ_EN, read/write, low NSW bits used.
- Any other I/O offset SHALL read 0 and ignore writes.

REQ-006 An I/O write SHALL take effect on the rising clk edge where we_x=1 and the address is in I/O space; non-I/O writes SHALL NOT alter any register.

REQ-007 If both ports write the same register in one cycle, port A's data SHALL win (for SW_EDGE, the clear mask is wd_a only).

REQ-008 Read latency SHALL be 1 cycle, matching block RAM:
- addr_x and its I/O-select flag are registered on the rising edge.
- rdata_x is selected from the registered select: I/O register value or memq_x.
- The I/O register value is taken at the current cycle, so a write in cycle N is visible to a read whose data returns in cycle N+1.

REQ-009 Switch synchronisation:
- switches pass through a 2-flop synchroniser per bit.
- The synchronised vector is sync.

REQ-010 Debounce SHALL use one shared counter:
- If sync != debounced, the counter increments.
- When the counter reaches DEBOUNCE-1 with sync still != debounced, debounced <= sync and the counter clears.
- If sync == debounced, the counter clears.

REQ-011 A 0->1 transition of any debounced bit SHALL set the matching SW_EDGE bit on the same edge where debounced updates.

REQ-012 If an edge set and a W1C clear hit the same SW_EDGE bit in the same cycle, the set SHALL win.

REQ-013 irq SHALL be registered: irq <= |(SW_EDGE & IRQ_EN), evaluated on the values after the current cycle's update (one cycle after the flag/enable changes).

REQ-014 Writes to SW_DATA SHALL be ignored.

REQ-015 Address bits above offset [3:0] inside I/O space (other than the two select bits) SHALL be don't-care; the register set aliases.

Reset
REQ-016 While reset=0, the following SHALL all be 0 asynchronously:
- outregs, SW_EDGE, IRQ_EN, debounced, the synchroniser flops, the debounce counter.
- the registered address/select flags, rdata_a, rdata_b, and irq.

REQ-017 After reset release, debounced SHALL track switches only via the normal DEBOUNCE path; no edges are flagged for bits that are 0 at release.

REQ-018 Reset asserted mid-debounce SHALL discard the pending count; the switch value is re-qualified after release.

Verification
REQ-019 OUT write/read: port A writes 0x1234 to addr 0x300 -> outregs[15:0]=0x1234 next edge; read 0x300 -> rdata_a=0x1234 one cycle later.

REQ-020 Memory path: read addr 0x005 with memq_a=0xBEEF -> rdata_a=0xBEEF one cycle later; write 0x0005 to 0x005 -> outregs unchanged.

REQ-021 Dual-port collision: A writes 0xAAAA and B writes 0x5555 to 0x301 in one cycle -> OUT[1]=0xAAAA; B's read of 0x301 next cycle returns 0xAAAA.

REQ-022 Debounce glitch, DEBOUNCE=4:
- switches[0] high for 3 cycles then low -> SW_DATA stays 0, no edge.
- held high 10 cycles -> SW_DATA=0x0001 within 2+4 cycles, SW_EDGE[0]=1.

REQ-023 Interrupt:
- IRQ_EN=0x0001 with SW_EDGE[0]=1 -> irq=1 next cycle.
- Write 0x0001 to 0x309 -> SW_EDGE=0, irq=0 one cycle later.
- A clear coincident with a new edge -> flag stays 1.

REQ-024 Reset mid-operation: reset pulled low with OUT[0]=0xFFFF and irq=1 -> both 0 immediately; 0x300 reads 0 after release.
